// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready select handshake and out-of-range flag.
// Define ONEHOT_DECODER_SCAN_EN to compile in the auto-scan mode with programmable dwell.
module onehot_decoder_seq #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               err,
    output logic               scan_wrap
);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
    logic               err_q, err_d;
    logic               in_range;

    assign in_range = 32'(sel) < NUM_OUT;

`ifdef ONEHOT_DECODER_SCAN_EN
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_m1;
    logic               scan_wrap_q, scan_wrap_d;
    logic               last_idx;

    // Counter reloads with max(dwell,1)-1 so a dwell of 0 behaves as 1.
    assign dwell_m1  = (dwell == '0) ? '0 : dwell - 1'b1;
    assign last_idx  = (cur_idx_q == SEL_W'(NUM_OUT - 1));
    assign sel_ready = en && !mode;
    assign scan_wrap = scan_wrap_q;
`else
    logic unused_scan;

    assign unused_scan = ^{mode, dwell, state_q};
    assign sel_ready   = en;
    assign scan_wrap   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cur_idx_d   = cur_idx_q;
        err_d       = 1'b0;
`ifdef ONEHOT_DECODER_SCAN_EN
        cnt_d       = cnt_q;
        scan_wrap_d = 1'b0;
`endif
        if (!en) begin
            state_d     = StIdle;
            out_d       = '0;
            out_valid_d = 1'b0;
        end
`ifdef ONEHOT_DECODER_SCAN_EN
        else if (mode) begin
            state_d = StScan;
            if (state_q != StScan) begin
                cur_idx_d   = '0;
                out_d       = NUM_OUT'(1);
                out_valid_d = 1'b1;
                cnt_d       = dwell_m1;
            end else if (cnt_q == '0) begin
                cur_idx_d   = last_idx ? '0 : cur_idx_q + 1'b1;
                scan_wrap_d = last_idx;
                out_d       = NUM_OUT'(1) << cur_idx_d;
                out_valid_d = 1'b1;
                cnt_d       = dwell_m1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
`endif
        else begin
            // sel_ready is high here, so sel_valid alone marks a transfer.
            state_d = StDirect;
            if (sel_valid) begin
                if (in_range) begin
                    out_d       = NUM_OUT'(1) << sel;
                    out_valid_d = 1'b1;
                    cur_idx_d   = sel;
                end else begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    err_d       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cur_idx_q   <= '0;
            err_q       <= 1'b0;
`ifdef ONEHOT_DECODER_SCAN_EN
            cnt_q       <= '0;
            scan_wrap_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cur_idx_q   <= cur_idx_d;
            err_q       <= err_d;
`ifdef ONEHOT_DECODER_SCAN_EN
            cnt_q       <= cnt_d;
            scan_wrap_q <= scan_wrap_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cur_idx   = cur_idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq (SEL_W=3, NUM_OUT=6).
// Scan checks are included only when ONEHOT_DECODER_SCAN_EN is defined.
module tb_onehot_decoder_seq;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned NUM_OUT = 6;
    localparam int unsigned DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [NUM_OUT-1:0] out;
    logic               out_valid;
    logic [SEL_W-1:0]   cur_idx;
    logic               err;
    logic               scan_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq #(
        .SEL_W  (SEL_W),
        .NUM_OUT(NUM_OUT),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .sel      (sel),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .dwell    (dwell),
        .out      (out),
        .out_valid(out_valid),
        .cur_idx  (cur_idx),
        .err      (err),
        .scan_wrap(scan_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NUM_OUT-1:0] sweep_exp [NUM_OUT] = '{6'b000001, 6'b000010, 6'b000100,
                                                6'b001000, 6'b010000, 6'b100000};

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        sel_valid = 1'b0;
        dwell     = 8'd3;
        #2 rst_n  = 1'b0;
        tick();
        tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cur_idx", 32'(cur_idx), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_scan_wrap", 32'(scan_wrap), 32'h0);
        check("rst_sel_ready", 32'(sel_ready), 32'h0);

        // First transfer accepted on the edge en is first sampled
        rst_n     = 1'b1;
        en        = 1'b1;
        sel       = 3'd2;
        sel_valid = 1'b1;
        #1 check("ready_en", 32'(sel_ready), 32'h1);
        tick();
        check("first_out", 32'(out), 32'h04);
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_idx", 32'(cur_idx), 32'h2);

        // Asynchronous reset mid-stream
        sel = 3'd4;
        tick();
        check("pre_rst_out", 32'(out), 32'h10);
        sel_valid = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_idx", 32'(cur_idx), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Back-to-back sweep, one output per cycle
        sel_valid = 1'b1;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            sel = SEL_W'(i);
            tick();
            check($sformatf("sweep_out_%0d", i), 32'(out), 32'(sweep_exp[i]));
            check($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("sweep_idx_%0d", i), 32'(cur_idx), 32'(i));
        end
        sel_valid = 1'b0;
        sel       = 3'd0;
        tick();
        tick();
        check("hold_out", 32'(out), 32'h20);
        check("hold_valid", 32'(out_valid), 32'h1);
        check("hold_idx", 32'(cur_idx), 32'h5);

        // Out-of-range selects give back-to-back err pulses
        sel_valid = 1'b1;
        sel       = 3'd6;
        tick();
        check("oor6_err", 32'(err), 32'h1);
        check("oor6_out", 32'(out), 32'h0);
        check("oor6_valid", 32'(out_valid), 32'h0);
        check("oor6_idx", 32'(cur_idx), 32'h5);
        sel = 3'd7;
        tick();
        check("oor7_err", 32'(err), 32'h1);
        check("oor7_out", 32'(out), 32'h0);
        check("oor7_valid", 32'(out_valid), 32'h0);
        check("oor7_idx", 32'(cur_idx), 32'h5);
        sel = 3'd1;
        tick();
        check("recover_err", 32'(err), 32'h0);
        check("recover_out", 32'(out), 32'h02);
        check("recover_valid", 32'(out_valid), 32'h1);
        check("recover_idx", 32'(cur_idx), 32'h1);

        // Dropping en: output clears, index holds, no transfer accepted
        sel = 3'd3;
        tick();
        check("pre_dis_out", 32'(out), 32'h08);
        en  = 1'b0;
        sel = 3'd0;
        #1 check("dis_ready", 32'(sel_ready), 32'h0);
        tick();
        check("dis_out", 32'(out), 32'h0);
        check("dis_valid", 32'(out_valid), 32'h0);
        check("dis_idx", 32'(cur_idx), 32'h3);
        check("dis_err", 32'(err), 32'h0);

`ifdef ONEHOT_DECODER_SCAN_EN
        // Scan with dwell 3, then dwell 0 applied from the next index
        en        = 1'b1;
        mode      = 1'b1;
        dwell     = 8'd3;
        sel       = 3'd1;
        sel_valid = 1'b1;
        #1 check("scan_ready", 32'(sel_ready), 32'h0);
        tick();
        check("scan_entry_out", 32'(out), 32'h01);
        check("scan_entry_valid", 32'(out_valid), 32'h1);
        check("scan_entry_idx", 32'(cur_idx), 32'h0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            check($sformatf("scan3_out_%0d", k), 32'(out), 32'(1) << ((k / 3) % 6));
            check($sformatf("scan3_wrap_%0d", k), 32'(scan_wrap), 32'(k == 18));
        end
        dwell = 8'd0;
        for (int k = 19; k <= 26; k++) begin
            tick();
            check($sformatf("scan0_idx_%0d", k), 32'(cur_idx),
                  32'((k < 21) ? 0 : (k - 20) % 6));
            check($sformatf("scan0_wrap_%0d", k), 32'(scan_wrap), 32'(k == 26));
        end
        tick();
        tick();
        check("scan_idx2", 32'(cur_idx), 32'h2);

        // Mode falls: transfer accepted on that same edge
        mode = 1'b0;
        sel  = 3'd5;
        #1 check("s2d_ready", 32'(sel_ready), 32'h1);
        tick();
        check("s2d_out", 32'(out), 32'h20);
        check("s2d_idx", 32'(cur_idx), 32'h5);
        check("s2d_valid", 32'(out_valid), 32'h1);
        check("s2d_wrap", 32'(scan_wrap), 32'h0);
`else
        // Scan compiled out: mode is ignored
        en        = 1'b1;
        mode      = 1'b1;
        sel       = 3'd1;
        sel_valid = 1'b1;
        #1 check("noscan_ready", 32'(sel_ready), 32'h1);
        tick();
        check("noscan_out", 32'(out), 32'h02);
        check("noscan_valid", 32'(out_valid), 32'h1);
        sel_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("noscan_wrap_%0d", k), 32'(scan_wrap), 32'h0);
            check($sformatf("noscan_hold_%0d", k), 32'(out), 32'h02);
        end
`endif

        sel_valid = 1'b0;
        en        = 1'b0;
        tick();
        check("final_out", 32'(out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Parametrised, registered binary-to-one-hot decoder; the successor to the team's fixed 2-to-4 decoder. Generalises select width and output count, registers the output behind a valid/ready handshake, flags out-of-range selects instead of silently outputting zero, and optionally auto-scans the outputs with a programmable dwell. It sits between control logic and multi-target enable/chip-select fabrics, such as bank select or LED/mux strobing.

## Interface
- SEL_W, 2, select width in bits (1..8)
- NUM_OUT, 4, number of one-hot outputs; 2 ≤ NUM_OUT ≤ 2**SEL_W
- DWELL_W, 8, width of dwell count input (scan mode only)

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; low forces IDLE
- mode  in  1  0 = direct decode, 1 = scan (scan requires ONEHOT_DECODER_SCAN_EN)
- sel  in  SEL_W  binary select, direct mode
- sel_valid  in  1  sel is valid this cycle
- sel_ready  out  1  combinational: en && (mode==0 || scan compiled out)
- dwell  in  DWELL_W  cycles each output is held in scan mode (0 treated as 1)
- out  out  NUM_OUT  registered one-hot output
- out_valid  out  1  out holds a valid one-hot code
- cur_idx  out  SEL_W  index of the currently asserted bit
- err  out  1  one-cycle pulse: out-of-range select accepted
- scan_wrap  out  1  one-cycle pulse when scan wraps from NUM_OUT-1 to 0

## Operation
- States: IDLE, DIRECT, SCAN. Evaluated every clock edge; en low has highest priority.
- Reset (async, rst_n=0): state=IDLE, out=0, out_valid=0, cur_idx=0, err=0, scan_wrap=0, dwell counter=0. Takes effect immediately; a reset mid-scan or mid-transfer discards all progress.
- IDLE: out=0, out_valid=0. If en && mode==0 → DIRECT. If en && mode==1 → SCAN.
- DIRECT: a transfer occurs when sel_valid && sel_ready on a clock edge.
  - sel < NUM_OUT: next cycle out = 1<<sel, out_valid=1, cur_idx=sel.
  - sel ≥ NUM_OUT: next cycle out=0, out_valid=0, err=1 for exactly one cycle; cur_idx unchanged.
  - No transfer: out, out_valid and cur_idx hold.
- DIRECT→SCAN (mode rises): a pending sel_valid is ignored, since sel_ready is already low. The next cycle starts the scan at index 0.
- SCAN: out = 1<<cur_idx, out_valid=1.
  - The dwell counter counts cycles. After max(dwell,1) cycles on an index, cur_idx advances by 1.
  - dwell is sampled at each advance; a change mid-dwell applies to the next index.
  - At cur_idx=NUM_OUT-1 the advance wraps to 0 and scan_wrap pulses for one cycle, coincident with out=1<<0.
- SCAN→DIRECT (mode falls): out and cur_idx hold and sel_ready asserts the same cycle. A transfer on that edge takes effect normally.
- en falls in any state: next cycle state=IDLE, out=0, out_valid=0; cur_idx holds; err and scan_wrap are 0.
- When out_valid=1, out is always exactly one-hot; err and out_valid are never high in the same cycle.

## Timing
- Direct decode latency: 1 cycle from the accepting edge to out/out_valid.
- err latency: 1 cycle; pulse width exactly 1 cycle. Back-to-back bad selects give back-to-back pulses.
- Scan entry: first out (index 0) is visible 1 cycle after the edge where en && mode==1 is first sampled.
- Scan period: sum of the effective dwells over NUM_OUT indices. With a constant dwell D≥1 the period is NUM_OUT*D cycles, and scan_wrap pulses every NUM_OUT*D cycles.
- Throughput: one direct transfer per cycle; no bubbles.
- All outputs except sel_ready are registered.

## Configuration
- ONEHOT_DECODER_SCAN_EN defined: SCAN state, dwell counter and scan_wrap logic are compiled in; mode behaves as specified.
- ONEHOT_DECODER_SCAN_EN undefined: scan logic is absent; mode and dwell are ignored; the block is always DIRECT when en=1; scan_wrap is tied to 0.

## Test plan
- Reset, SEL_W=2, NUM_OUT=4: apply rst_n=0 mid-stream → out=0, out_valid=0, cur_idx=0, err=0 immediately; then en=1, sel=2'b10 with valid → next cycle out=4'b0100, out_valid=1.
- Sweep, SEL_W=3, NUM_OUT=6: sel=0..5 back-to-back → out=000001…100000, one per cycle, 1-cycle latency; then hold sel_valid=0 → out holds 100000.
- Out-of-range, SEL_W=3, NUM_OUT=6: sel=6 then sel=7 → err high 2 consecutive cycles, out=0, out_valid=0, cur_idx stays 5; then sel=1 → out=000010.
- Scan, NUM_OUT=4, dwell=3: en=1, mode=1 → out=0001 for 3 cycles, then 0010, 0100, 1000; scan_wrap pulses with the return to 0001 after 12 cycles. Repeat with dwell=0 → 1 cycle per index.
- Mode/enable edges: mode 1→0 while cur_idx=2 with sel=3 valid on the same edge → sel_ready=1 that cycle, next out=1000. Dropping en → out=0 next cycle, cur_idx held, sel_ready=0.
- Build with ONEHOT_DECODER_SCAN_EN undefined: mode=1, en=1, sel=1 valid → sel_ready=1, out=0010; scan_wrap stays 0.
